// File: rtl/cci_rd_port_mux.sv
// ---------------------------------------------------------------------------
// cci_rd_port_mux
//
// Multiplexes NUM_PORTS application read-request streams onto one CCI-P c0
// read channel. Requests are granted round-robin, and each request's mdata is
// tagged with the port index. Read responses are steered back to the port
// named by that tag. Each port has an outstanding-read limit, and no grant is
// issued while the shared channel reports almost-full.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_addr/req_mdata per-port request (port i at slice i)
//   req_ready                    one-hot grant (accept = valid && ready)
//   tx_valid/tx_addr/tx_mdata    registered request to the shared channel,
//                                tx_mdata = {port, port mdata}
//   tx_alm_full                  shared-channel almost-full
//   rsp_valid_in/rsp_mdata_in/rsp_data_in  tagged response from the channel
//   rsp_valid                    one-hot per-port response strobe
//   rsp_mdata/rsp_data           untagged response, broadcast to all ports
//   idle                         no reads outstanding and tx register empty
//   err                          sticky: bad response tag or response with
//                                nothing outstanding
//
// Optional (macro CCI_RD_PORT_MUX_STATS_EN)
//   stat_clr                     synchronous clear of the grant counters
//   stat_grants                  per-port saturating 32-bit grant counters
// ---------------------------------------------------------------------------
module cci_rd_port_mux #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 12,
  parameter int MAX_OUTSTANDING = 64,
  localparam int PORT_BITS      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int TAG_W          = MDATA_W + PORT_BITS,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*MDATA_W-1:0]  req_mdata,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic                          tx_valid,
  output logic [ADDR_W-1:0]             tx_addr,
  output logic [TAG_W-1:0]              tx_mdata,
  input  logic                          tx_alm_full,
  input  logic                          rsp_valid_in,
  input  logic [TAG_W-1:0]              rsp_mdata_in,
  input  logic [511:0]                  rsp_data_in,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [MDATA_W-1:0]            rsp_mdata,
  output logic [511:0]                  rsp_data,
  output logic                          idle,
  output logic                          err
`ifdef CCI_RD_PORT_MUX_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_PORTS*32-1:0]       stat_grants
`endif
);

  if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_num_ports
    $error("cci_rd_port_mux: NUM_PORTS must be 1..16");
  end
  if (TAG_W > 16) begin : g_bad_tag_w
    $error("cci_rd_port_mux: MDATA_W + PORT_BITS must be <= 16");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
    $error("cci_rd_port_mux: MAX_OUTSTANDING must be >= 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [PORT_BITS-1:0] ptr, ptr_next, grant_idx, cand, rsp_port;
  logic [NUM_PORTS-1:0] elig, grant, rsp_hit, cnt_zero;
  logic                 grant_any, rsp_ok, err_set;
  logic [CNT_W-1:0]     cnt [NUM_PORTS];

  // Eligibility. rst_n is included so that req_ready stays low while the
  // block is held in reset, even though the counters read zero.
  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    elig     = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_zero[i] = (cnt[i] == '0);
      elig[i]     = rst_n && req_valid[i] && (cnt[i] < CNT_MAX) && !tx_alm_full;
    end
  end

  // Round-robin search. The first eligible port at or after ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PORT_BITS'((int'(ptr) + k) % NUM_PORTS);
      if (!grant_any && elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant    = grant_any ? (NUM_PORTS'(1) << grant_idx) : '0;
    ptr_next = grant_any ? PORT_BITS'((int'(grant_idx) + 1) % NUM_PORTS) : ptr;
  end

  assign req_ready = grant;

  // Response decode. A tag that names a non-existent port is dropped.
  // A response to a port with nothing outstanding is still delivered, but it
  // is flagged unless a grant to that port in the same cycle covers it.
  always_comb begin
    rsp_port = rsp_mdata_in[TAG_W-1 -: PORT_BITS];
    rsp_ok   = rsp_valid_in && (int'(rsp_port) < NUM_PORTS);
    rsp_hit  = rsp_ok ? (NUM_PORTS'(1) << rsp_port) : '0;
    err_set  = (rsp_valid_in && !rsp_ok) || (|(rsp_hit & cnt_zero & ~grant));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      tx_valid  <= 1'b0;
      rsp_valid <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      ptr       <= ptr_next;
      tx_valid  <= grant_any;
      rsp_valid <= rsp_hit;
      if (err_set) err <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[i] && !rsp_hit[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (rsp_hit[i] && !grant[i] && !cnt_zero[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the payload registers have no reset. They are qualified by
  // tx_valid/rsp_valid, which are reset, so any contents they hold after
  // reset are never consumed.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      tx_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
      tx_mdata <= {grant_idx, req_mdata[grant_idx*MDATA_W +: MDATA_W]};
    end
    if (rsp_valid_in) begin
      rsp_mdata <= rsp_mdata_in[MDATA_W-1:0];
      rsp_data  <= rsp_data_in;
    end
  end

  assign idle = !tx_valid && (&cnt_zero);

`ifdef CCI_RD_PORT_MUX_STATS_EN
  logic [31:0] stat_cnt [NUM_PORTS];

  // stat_clr takes priority over a grant in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (stat_clr) begin
          stat_cnt[i] <= '0;
        end else if (grant[i] && (stat_cnt[i] != '1)) begin
          stat_cnt[i] <= stat_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_PORTS; i++) stat_grants[i*32 +: 32] = stat_cnt[i];
  end
`endif

endmodule

// File: tb/tb_cci_rd_port_mux.sv
// ---------------------------------------------------------------------------
// tb_cci_rd_port_mux
//
// Directed bench for cci_rd_port_mux with the default parameters
// (4 ports, 42-bit address, 12-bit mdata, 64 outstanding). Each stimulus
// cycle states the grant it expects. Expected tx requests and port responses
// are queued when the stimulus is issued, and a negedge monitor pops and
// compares them whenever the DUT presents tx_valid or rsp_valid.
// ---------------------------------------------------------------------------
module tb_cci_rd_port_mux;
  localparam int N  = 4;
  localparam int AW = 42;
  localparam int MW = 12;
  localparam int PB = 2;
  localparam int TW = MW + PB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*MW-1:0]   req_mdata;
  logic [N-1:0]      req_ready;
  logic              tx_valid;
  logic [AW-1:0]     tx_addr;
  logic [TW-1:0]     tx_mdata;
  logic              tx_alm_full;
  logic              rsp_valid_in;
  logic [TW-1:0]     rsp_mdata_in;
  logic [511:0]      rsp_data_in;
  logic [N-1:0]      rsp_valid;
  logic [MW-1:0]     rsp_mdata;
  logic [511:0]      rsp_data;
  logic              idle;
  logic              err;
`ifdef CCI_RD_PORT_MUX_STATS_EN
  logic              stat_clr;
  logic [N*32-1:0]   stat_grants;
`endif

  always #5 clk = ~clk;

  cci_rd_port_mux dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_mdata    (req_mdata),
    .req_ready    (req_ready),
    .tx_valid     (tx_valid),
    .tx_addr      (tx_addr),
    .tx_mdata     (tx_mdata),
    .tx_alm_full  (tx_alm_full),
    .rsp_valid_in (rsp_valid_in),
    .rsp_mdata_in (rsp_mdata_in),
    .rsp_data_in  (rsp_data_in),
    .rsp_valid    (rsp_valid),
    .rsp_mdata    (rsp_mdata),
    .rsp_data     (rsp_data),
    .idle         (idle),
    .err          (err)
`ifdef CCI_RD_PORT_MUX_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_grants  (stat_grants)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [TW-1:0] md;
  } tx_t;

  typedef struct {
    logic [N-1:0]  v;
    logic [MW-1:0] md;
    logic [511:0]  d;
  } rsp_t;

  tx_t  tx_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] addr_c [N] = '{42'h0_1000_0040, 42'h1_2000_0080, 42'h2_3000_00C0, 42'h3_4000_0100};
  logic [MW-1:0] md_c   [N] = '{12'h5A0, 12'h5A1, 12'hF02, 12'h003};
  logic [TW-1:0] drain_tags [8] = '{14'h0A00, 14'h1A01, 14'h2ABC, 14'h3A03,
                                    14'h0A10, 14'h1A11, 14'h2A12, 14'h3A13};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive just after posedge, queue expectations, then
  // compare the combinational grant at the following negedge.
  task automatic cycle(input logic [N-1:0] rv, input logic alm, input logic rspv,
                       input logic [TW-1:0] rtag, input logic [N-1:0] exp_ready,
                       input string name);
    tx_t  t;
    rsp_t r;
    int   g;
    @(posedge clk);
    #1;
    req_valid    = rv;
    tx_alm_full  = alm;
    rsp_valid_in = rspv;
    rsp_mdata_in = rtag;
    rsp_data_in  = {16{16'hC0DE, 2'b00, rtag}};
    if (rspv) begin
      r.v  = N'(1) << rtag[TW-1 -: PB];
      r.md = rtag[MW-1:0];
      r.d  = {16{16'hC0DE, 2'b00, rtag}};
      rsp_q.push_back(r);
    end
    if (exp_ready != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (exp_ready[i]) g = i;
      t.addr = addr_c[g];
      t.md   = {PB'(g), md_c[g]};
      tx_q.push_back(t);
    end
    @(negedge clk);
    check(name, req_ready, exp_ready);
  endtask

  task automatic idle_cycle();
    cycle('0, 1'b0, 1'b0, '0, '0, "idle_ready");
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    tx_t  et;
    rsp_t er;
    if (rst_n && tx_valid) begin
      check("tx_expected_pending", tx_q.size() != 0, 1'b1);
      if (tx_q.size() != 0) begin
        et = tx_q.pop_front();
        check("tx_addr", tx_addr, et.addr);
        check("tx_mdata", tx_mdata, et.md);
      end
    end
    if (rst_n && rsp_valid != '0) begin
      check("rsp_expected_pending", rsp_q.size() != 0, 1'b1);
      if (rsp_q.size() != 0) begin
        er = rsp_q.pop_front();
        check("rsp_valid", rsp_valid, er.v);
        check("rsp_mdata", rsp_mdata, er.md);
        check("rsp_data", rsp_data, er.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int txn;
    req_valid    = 4'hF;
    tx_alm_full  = 1'b0;
    rsp_valid_in = 1'b0;
    rsp_mdata_in = '0;
    rsp_data_in  = '0;
    req_addr     = {addr_c[3], addr_c[2], addr_c[1], addr_c[0]};
    req_mdata    = {md_c[3], md_c[2], md_c[1], md_c[0]};
`ifdef CCI_RD_PORT_MUX_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset state, with requests pending so that ready gating is exercised.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_err", err, 1'b0);
    check("rst_idle", idle, 1'b1);
    req_valid = '0;
    rst_n     = 1'b1;

    // Round robin with every port requesting.
    for (int c = 0; c < 8; c++) cycle(4'hF, 1'b0, 1'b0, '0, N'(1) << (c % 4), "rr_grant");
    idle_cycle();
    check("rr_busy_idle", idle, 1'b0);

    // Drain two responses per port, including the 14'h2ABC case.
    for (int i = 0; i < 8; i++) cycle('0, 1'b0, 1'b1, drain_tags[i], '0, "drain_ready");
    idle_cycle();
    check("drain_idle", idle, 1'b1);
    check("drain_err", err, 1'b0);

    // Almost-full: one grant, five blocked cycles, then resume.
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b0001, "af_pre_grant");
    txn = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, 1'b1, 1'b0, '0, 4'b0000, "af_blocked");
      txn += int'(tx_valid);
    end
    check("af_tx_count", txn, 1);
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b0010, "af_resume");

    // Outstanding limit on port 2.
    for (int i = 0; i < 64; i++) cycle(4'b0100, 1'b0, 1'b0, '0, 4'b0100, "lim_fill");
    cycle(4'b0100, 1'b0, 1'b0, '0, 4'b0000, "lim_65th");
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b1000, "lim_others_3");
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b0001, "lim_others_0");
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b0010, "lim_others_1");
    cycle(4'b0100, 1'b0, 1'b1, 14'h2123, 4'b0000, "lim_rsp_cycle");
    cycle(4'b0100, 1'b0, 1'b1, 14'h2124, 4'b0100, "lim_regrant_same_rsp");
    cycle(4'b0100, 1'b0, 1'b0, '0, 4'b0100, "lim_last_slot");
    cycle(4'b0100, 1'b0, 1'b0, '0, 4'b0000, "lim_full_again");
    check("lim_err", err, 1'b0);

    // Port 3 has one read outstanding; the second response underflows.
    cycle('0, 1'b0, 1'b1, 14'h3B00, '0, "uf_rsp1");
    cycle('0, 1'b0, 1'b1, 14'h3B01, '0, "uf_rsp2");
    check("uf_err_before", err, 1'b0);
    idle_cycle();
    check("uf_err_set", err, 1'b1);
    idle_cycle();
    check("uf_err_sticky", err, 1'b1);

    // Asynchronous reset in the middle of a burst.
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b1000, "burst_3");
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b0001, "burst_0");
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b0010, "burst_1");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 4'b0000);
    check("mid_rst_req_ready", req_ready, 4'b0000);
    check("mid_rst_idle", idle, 1'b1);
    check("mid_rst_err", err, 1'b0);
    tx_q.delete();
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    idle_cycle();
    check("post_rst_idle", idle, 1'b1);
    cycle(4'hF, 1'b0, 1'b0, '0, 4'b0001, "post_rst_ptr0");
    idle_cycle();

`ifdef CCI_RD_PORT_MUX_STATS_EN
    for (int i = 0; i < 3; i++) cycle(4'b0010, 1'b0, 1'b0, '0, 4'b0010, "stat_grant1");
    idle_cycle();
    check("stat_port1", stat_grants[63:32], 32'd3);
    check("stat_port0", stat_grants[31:0], 32'd1);
    @(posedge clk);
    #1;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_cleared", stat_grants[63:32], 32'd0);
`endif

    repeat (3) idle_cycle();
    check("tx_q_drained", tx_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
